// File: rtl/pipe_hazard_unit.sv
// ============================================================================
// pipe_hazard_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Data-hazard detection and forwarding-select for an in-order pipeline.
//   A small scoreboard follows every instruction issued from ID through
//   stages 1 (EX) .. DEPTH (WB). ID source registers are compared against it
//   to produce the stall request and the forwarding mux selects. Redirect
//   requests from EX are passed through as a flush. Stall and flush cycles
//   are counted in saturating counters.
//
// Build option:
//   PIPE_FORWARD_EN  defined   -> results forward from stages 1..DEPTH-1;
//                                 only an adjacent load-use stalls (one bubble).
//                    undefined -> no forwarding (fwd_a/fwd_b tied to 0); any
//                                 producer in stages 1..DEPTH-1 stalls ID until
//                                 it reaches the write-through stage DEPTH.
//
// Parameters:
//   AW     register-address width
//   DEPTH  tracked stages after ID (1 = EX, DEPTH = WB), 2..8
//   CW     event-counter width
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   id_valid     in   a real instruction is in ID
//   id_rs/id_rt  in   ID source registers           [AW]
//   id_use_rs/rt in   the corresponding source is read
//   id_dst       in   ID destination register       [AW]
//   id_regwrite  in   ID writes id_dst
//   id_memread   in   ID is a load
//   flush_req    in   taken branch / jump / IRQ / exception resolved in EX
//   stall        out  hold PC and IF/ID, bubble into EX
//   flush        out  squash IF/ID and the ID instruction
//   fwd_a/fwd_b  out  0 = register file, k = stage-k result
//   stall_cnt    out  saturating count of stall cycles  [CW]
//   flush_cnt    out  saturating count of flush cycles  [CW]
// ============================================================================
module pipe_hazard_unit #(
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int CW    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         id_valid,
    input  logic [AW-1:0]                id_rs,
    input  logic [AW-1:0]                id_rt,
    input  logic                         id_use_rs,
    input  logic                         id_use_rt,
    input  logic [AW-1:0]                id_dst,
    input  logic                         id_regwrite,
    input  logic                         id_memread,
    input  logic                         flush_req,
    output logic                         stall,
    output logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_a,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_b,
    output logic [CW-1:0]                stall_cnt,
    output logic [CW-1:0]                flush_cnt
);

    localparam int FW = $clog2(DEPTH+1);

    // Scoreboard, index k = pipeline stage k.
    logic [DEPTH:1]  sb_valid_q;
    logic [DEPTH:1]  sb_wr_q;
    logic [DEPTH:1]  sb_load_q;
    logic [AW-1:0]   sb_dst_q [1:DEPTH];

    logic [DEPTH:1]  hit_rs;
    logic [DEPTH:1]  hit_rt;
    logic            hazard;
    logic [FW-1:0]   sel_a;
    logic [FW-1:0]   sel_b;
    logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CW-1:0]   flush_cnt_q, flush_cnt_d;

    assign flush = flush_req;
    // Redirect wins over stall; reset and an empty ID slot never stall.
    assign stall = reset & id_valid & ~flush_req & hazard;

    genvar gi;
    generate
        for (gi = 1; gi <= DEPTH; gi++) begin : g_stage
            if (gi == 1) begin : g_head
                // A stalled or flushed ID instruction enters EX as a bubble.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        sb_valid_q[gi] <= 1'b0;
                        sb_wr_q[gi]    <= 1'b0;
                        sb_load_q[gi]  <= 1'b0;
                        sb_dst_q[gi]   <= '0;
                    end else begin
                        sb_valid_q[gi] <= id_valid & ~stall & ~flush;
                        sb_wr_q[gi]    <= id_regwrite;
                        sb_load_q[gi]  <= id_memread;
                        sb_dst_q[gi]   <= id_dst;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        sb_valid_q[gi] <= 1'b0;
                        sb_wr_q[gi]    <= 1'b0;
                        sb_load_q[gi]  <= 1'b0;
                        sb_dst_q[gi]   <= '0;
                    end else begin
                        sb_valid_q[gi] <= sb_valid_q[gi-1];
                        sb_wr_q[gi]    <= sb_wr_q[gi-1];
                        sb_load_q[gi]  <= sb_load_q[gi-1];
                        sb_dst_q[gi]   <= sb_dst_q[gi-1];
                    end
                end
            end

            // $0 is hard-wired, so it is never a hazard or forward source.
            assign hit_rs[gi] = sb_valid_q[gi] & sb_wr_q[gi] & id_use_rs &
                                (sb_dst_q[gi] == id_rs) & (id_rs != '0);
            assign hit_rt[gi] = sb_valid_q[gi] & sb_wr_q[gi] & id_use_rt &
                                (sb_dst_q[gi] == id_rt) & (id_rt != '0);
        end
    endgenerate

    // Stage DEPTH writes through to the register file, so its match is
    // deliberately ignored; the load flag of the last stage is only carried.
    logic unused_bits;
    assign unused_bits = hit_rs[DEPTH] ^ hit_rt[DEPTH] ^ (^sb_load_q);

`ifdef PIPE_FORWARD_EN
    // A load in EX has no data yet: that is the only stall case.
    assign hazard = (hit_rs[1] | hit_rt[1]) & sb_load_q[1];

    // Descending scan so the youngest (smallest k) match is written last.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = DEPTH-1; k >= 1; k--) begin
            if (hit_rs[k] && !(k == 1 && sb_load_q[1])) sel_a = FW'(k);
            if (hit_rt[k] && !(k == 1 && sb_load_q[1])) sel_b = FW'(k);
        end
    end
`else
    assign hazard = |(hit_rs[DEPTH-1:1] | hit_rt[DEPTH-1:1]);
    assign sel_a  = {FW{1'b0}};
    assign sel_b  = {FW{1'b0}};
`endif

    assign fwd_a = reset ? sel_a : {FW{1'b0}};
    assign fwd_b = reset ? sel_b : {FW{1'b0}};

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != {CW{1'b1}})) stall_cnt_d = stall_cnt_q + CW'(1);
        if (flush && (flush_cnt_q != {CW{1'b1}})) flush_cnt_d = flush_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// ============================================================================
// tb_pipe_hazard_unit
// ----------------------------------------------------------------------------
// Random and directed stimulus for pipe_hazard_unit (AW=5, DEPTH=3, CW=4).
// The driver keeps a reference model of instructions in flight, predicts the
// hazard outputs per cycle and queues them; a monitor pops and compares at
// each falling edge. Compile with or without PIPE_FORWARD_EN to match the RTL.
// ============================================================================
module tb_pipe_hazard_unit;

    localparam int AW    = 5;
    localparam int DEPTH = 3;
    localparam int CW    = 4;
    localparam int FWW   = $clog2(DEPTH+1);
    localparam int CMAX  = (1 << CW) - 1;
`ifdef PIPE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            id_valid = 1'b0;
    logic [AW-1:0]   id_rs = '0, id_rt = '0, id_dst = '0;
    logic            id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic            id_regwrite = 1'b0, id_memread = 1'b0, flush_req = 1'b0;
    logic            stall, flush;
    logic [FWW-1:0]  fwd_a, fwd_b;
    logic [CW-1:0]   stall_cnt, flush_cnt;

    pipe_hazard_unit #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush_req(flush_req), .stall(stall), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; int dst; bit wr; bit ld; } insn_t;
    typedef struct { int stall; int flush; int fa; int fb; int sc; int fc; } exp_t;

    insn_t hist [DEPTH+1];       // hist[s] = instruction now in stage s
    int    model_sc, model_fc;
    exp_t  exp_q [$];
    int    n_checks = 0, n_pass = 0;
    int    last_stall, last_flush, last_fa, last_fb, last_sc, last_fc;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    endtask

    function automatic void model_clear();
        for (int s = 0; s <= DEPTH; s++) hist[s] = '{1'b0, 0, 1'b0, 1'b0};
        model_sc = 0;
        model_fc = 0;
    endfunction

    // A producer's value is usable from the stage where it exists: ALU results
    // after EX (stage 1), loads after MEM (stage 2), everything at WB without
    // forwarding. An older producer than that stalls; a ready one forwards,
    // the youngest in-flight producer taking precedence.
    function automatic void resolve(input int r, input bit used, output bit hz, output int fw);
        hz = 1'b0;
        fw = 0;
        if (!used || r == 0) return;
        for (int s = DEPTH-1; s >= 1; s--) begin
            int ready;
            ready = FWD ? (hist[s].ld ? 2 : 1) : DEPTH;
            if (hist[s].v && hist[s].wr && hist[s].dst == r) begin
                if (s < ready) hz = 1'b1;
                else fw = s;
            end
        end
    endfunction

    task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int dst, input bit wr, input bit ld, input bit fr, input bit rst_n);
        exp_t e;
        bit   hza, hzb;
        int   fa, fb;
        id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt);
        id_use_rs = urs; id_use_rt = urt; id_dst = AW'(dst);
        id_regwrite = wr; id_memread = ld; flush_req = fr; reset = rst_n;
        if (!rst_n) model_clear();
        resolve(rs, urs, hza, fa);
        resolve(rt, urt, hzb, fb);
        e.stall = (rst_n && v && !fr && (hza || hzb)) ? 1 : 0;
        e.flush = fr ? 1 : 0;
        e.fa = rst_n ? fa : 0;
        e.fb = rst_n ? fb : 0;
        e.sc = model_sc;
        e.fc = model_fc;
        exp_q.push_back(e);
        @(negedge clk);
        last_stall = int'(stall); last_flush = int'(flush);
        last_fa = int'(fwd_a); last_fb = int'(fwd_b);
        last_sc = int'(stall_cnt); last_fc = int'(flush_cnt);
        @(posedge clk);
        if (!rst_n) model_clear();
        else begin
            for (int s = DEPTH; s >= 2; s--) hist[s] = hist[s-1];
            hist[1] = '{v && !e.stall && !fr, dst, wr, ld};
            if (e.stall == 1 && model_sc < CMAX) model_sc++;
            if (fr && model_fc < CMAX) model_fc++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Presents one instruction, holding it in ID while the DUT stalls.
    task automatic issue(input int rs, input int rt, input bit urs, input bit urt,
                         input int dst, input bit wr, input bit ld, output int nstall);
        int guard;
        nstall = 0;
        guard = 0;
        do begin
            step(1, rs, rt, urs, urt, dst, wr, ld, 0, 1);
            if (last_stall == 1) nstall++;
            guard++;
        end while (last_stall == 1 && guard < 16);
        if (guard >= 16) chk("issue_timeout", guard, 0);
    endtask

    // Monitor: every cycle the DUT presents a full output set.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall", int'(stall), e.stall);
                chk("flush", int'(flush), e.flush);
                chk("fwd_a", int'(fwd_a), e.fa);
                chk("fwd_b", int'(fwd_b), e.fb);
                chk("stall_cnt", int'(stall_cnt), e.sc);
                chk("flush_cnt", int'(flush_cnt), e.fc);
            end
        end
    end

    initial begin
        int ns;
        model_clear();
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_stall_cnt", last_sc, 0);

        // lw $8 ; add $9,$8,$8
        issue(0, 0, 0, 0, 8, 1, 1, ns);
        issue(8, 8, 1, 1, 9, 1, 0, ns);
        chk("ldu_stalls", ns, FWD ? 1 : 2);
        chk("ldu_fwd_a", last_fa, FWD ? 2 : 0);
        chk("ldu_fwd_b", last_fb, FWD ? 2 : 0);
        chk("ldu_stall_cnt", last_sc, FWD ? 1 : 2);
        idle(3);

        // add $8 ; sub $10,$8,$3
        issue(0, 0, 0, 0, 8, 1, 0, ns);
        issue(8, 3, 1, 1, 10, 1, 0, ns);
        chk("alu_stalls", ns, FWD ? 0 : 2);
        chk("alu_fwd_a", last_fa, FWD ? 1 : 0);
        chk("alu_fwd_b", last_fb, 0);
        idle(3);

        // lw $0 ; add $1,$0,$0
        issue(0, 0, 0, 0, 0, 1, 1, ns);
        issue(0, 0, 1, 1, 1, 1, 0, ns);
        chk("r0_stalls", ns, 0);
        chk("r0_fwd_a", last_fa, 0);
        chk("r0_fwd_b", last_fb, 0);
        idle(3);

        // load-use coinciding with a redirect: flush wins, consumer squashed
        issue(0, 0, 0, 0, 8, 1, 1, ns);
        step(1, 8, 8, 1, 1, 9, 1, 0, 1, 1);
        chk("flushld_stall", last_stall, 0);
        chk("flushld_flush", last_flush, 1);
        idle(1);
        chk("flushld_flush_cnt", last_fc, 1);
        issue(9, 0, 1, 0, 11, 1, 0, ns);
        chk("flushld_bubble", ns, 0);
        idle(3);

        // lw $5 ; add $5 ; consumer of $5 -> youngest producer wins
        issue(0, 0, 0, 0, 5, 1, 1, ns);
        issue(0, 0, 0, 0, 5, 1, 0, ns);
        issue(5, 5, 1, 1, 12, 1, 0, ns);
        chk("young_stalls", ns, FWD ? 0 : 2);
        chk("young_fwd_a", last_fa, FWD ? 1 : 0);
        chk("young_fwd_b", last_fb, FWD ? 1 : 0);
        idle(3);

        // counter saturation and clear
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            issue(0, 0, 0, 0, 8, 1, 1, ns);
            issue(8, 0, 1, 0, 9, 1, 0, ns);
        end
        idle(1);
        chk("sat_stall_cnt", last_sc, CMAX);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_cleared", last_sc, 0);

        // reset asserted in the middle of a load-use stall
        issue(0, 0, 0, 0, 8, 1, 1, ns);
        step(1, 8, 0, 1, 0, 9, 1, 0, 0, 1);
        chk("midrst_pre_stall", last_stall, 1);
        step(1, 8, 0, 1, 0, 9, 1, 0, 0, 0);
        chk("midrst_stall", last_stall, 0);
        step(1, 8, 0, 1, 0, 9, 1, 0, 0, 1);
        chk("postrst_stall", last_stall, 0);
        chk("postrst_fwd_a", last_fa, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 99) != 0);
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, meaning tracked stages after ID; stage 1 = EX, stage DEPTH = WB; legal range 2..8.
REQ-003 SHALL have parameter CW, default 16, meaning event-counter width.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-006 SHALL have port id_valid, input, 1, a real instruction is in ID.
REQ-007 SHALL have ports id_rs and id_rt, input, AW each, ID source registers.
REQ-008 SHALL have ports id_use_rs and id_use_rt, input, 1 each, the corresponding source is read.
REQ-009 SHALL have port id_dst, input, AW, ID destination register after RegDst selection.
REQ-010 SHALL have port id_regwrite, input, 1, ID writes id_dst.
REQ-011 SHALL have port id_memread, input, 1, ID is a load.
REQ-012 SHALL have port flush_req, input, 1, taken branch, jump, IRQ or exception resolved in EX.
REQ-013 SHALL have port stall, output, 1, hold PC and IF/ID and insert a bubble into EX.
REQ-014 SHALL have port flush, output, 1, squash IF/ID and the ID instruction.
REQ-015 SHALL have ports fwd_a and fwd_b, output, clog2(DEPTH+1) each, 0 = register file, k = stage-k result.
REQ-016 SHALL have ports stall_cnt and flush_cnt, output, CW each, event counters.

Function
REQ-017 SHALL keep per-stage scoreboard entries {valid, dst, wr, load} for stages 1..DEPTH, advancing one stage per clk.
REQ-018 SHALL load stage 1 each clk from ID with valid = id_valid & ~stall & ~flush; otherwise stage 1 SHALL become a bubble (valid=0).
REQ-019 SHALL define a hazard match at stage k as: valid, wr, dst == source, source used, and source != 0.
REQ-020 SHALL never treat register 0 as a hazard or forward source.
REQ-021 SHALL drive flush = flush_req combinationally in the same cycle.
REQ-022 SHALL force stall = 0 when flush_req = 1, with flush taking priority.
REQ-023 SHALL treat stage DEPTH as write-through to the register file, never causing stall.
REQ-024 SHALL assert stall only while id_valid = 1.
REQ-025 SHALL assert stall for a load-use case until the load reaches stage 2, giving exactly one bubble for an adjacent load-use.
REQ-026 SHALL select for fwd_a/fwd_b the youngest (smallest k) matching stage in 1..DEPTH-1, excluding stage 1 when its load = 1.
REQ-027 SHALL output fwd_a/fwd_b = 0 when no stage matches.
REQ-028 SHALL compute stall, flush, fwd_a and fwd_b combinationally from ID inputs and registered scoreboard state, with zero latency.
REQ-029 SHALL increment stall_cnt on each clk with stall = 1, saturating at all-ones.
REQ-030 SHALL increment flush_cnt on each clk with flush = 1, saturating at all-ones.

Reset
REQ-031 SHALL, while reset = 0, clear all scoreboard valid bits, dst, wr and load to 0 asynchronously.
REQ-032 SHALL, while reset = 0, clear stall_cnt and flush_cnt to 0.
REQ-033 SHALL, while reset = 0, drive stall = 0, flush = flush_req and fwd_a = fwd_b = 0.
REQ-034 SHALL, on reset assertion mid-stall, drop stall once the scoreboard clears, and the first post-reset instruction SHALL see no hazards.

Configuration
REQ-035 SHALL, with macro PIPE_FORWARD_EN defined, behave per REQ-025/026.
REQ-036 SHALL, without PIPE_FORWARD_EN, tie fwd_a = fwd_b = 0 and stall on any match in stages 1..DEPTH-1 regardless of load, until the producer reaches stage DEPTH.

Verification
REQ-037 SHALL be verified with: lw $8 then add $9,$8,$8 with FORWARD_EN -> one stall cycle, then fwd_a = fwd_b = 2, stall_cnt = 1.
REQ-038 SHALL be verified with: add $8 then sub $10,$8,$3 with FORWARD_EN -> no stall, fwd_a = 1, fwd_b = 0; without FORWARD_EN -> 2 stall cycles (DEPTH=3), fwd = 0.
REQ-039 SHALL be verified with: producers writing $0 (lw $0; add $1,$0,$0) -> stall = 0, fwd = 0.
REQ-040 SHALL be verified with: load-use stall with flush_req = 1 in the same cycle -> stall = 0, flush = 1, stage 1 bubble, flush_cnt += 1.
REQ-041 SHALL be verified with: add $5 in stage 1 and lw $5 in stage 2, consumer reads $5 -> fwd = 1 (youngest wins).
REQ-042 SHALL be verified with: CW = 4 and 20 consecutive stall cycles -> stall_cnt holds at 15; reset pulse -> 0.
